// File: rtl/tlc_pkg.sv
// Shared definitions for the N-phase traffic-light controller:
// state encoding and the per-phase lamp pattern.
package tlc_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_ALLRED = 2'b10
    } tlc_state_e;

    // Lamp code for one phase, packed as {red, yellow, green}.
    function automatic logic [2:0] lamp_code(input tlc_state_e st, input logic is_cur);
        logic [2:0] code;
        code = 3'b100;
        case (st)
            ST_GREEN: begin
                if (is_cur) code = 3'b001;
                else        code = 3'b100;
            end
            ST_YELLOW: begin
                if (is_cur) code = 3'b010;
                else        code = 3'b100;
            end
            ST_ALLRED: code = 3'b100;
            default:   code = 3'b100;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin next-phase selector: first latched phase above cur_idx, with wrap.
module tlc_rr_pick #(
    parameter int N_PHASE = 2
) (
    input  logic [N_PHASE-1:0]         latch,
    input  logic [$clog2(N_PHASE)-1:0] cur_idx,
    output logic [$clog2(N_PHASE)-1:0] next_idx,
    output logic                       found
);
    localparam int IW = $clog2(N_PHASE);

    logic [IW-1:0] cand_s;

    // Scan offsets 1..N_PHASE so the current phase is considered last.
    always_comb begin
        next_idx = {IW{1'b0}};
        found    = 1'b0;
        cand_s   = {IW{1'b0}};
        for (int d = 1; d <= N_PHASE; d++) begin
            cand_s = IW'((int'(cur_idx) + d) % N_PHASE);
            if (!found && latch[cand_s]) begin
                found    = 1'b1;
                next_idx = cand_s;
            end else begin
                found    = found;
            end
        end
    end

endmodule

// File: rtl/tlc_phase_ctrl.sv
// N-phase traffic-light controller: GREEN -> YELLOW -> ALLRED per phase,
// tick-driven countdown, sticky demand latches and demand-driven phase skipping.
module tlc_phase_ctrl
    import tlc_pkg::*;
#(
    parameter int N_PHASE      = 2,
    parameter int CNT_W        = 5,
    parameter int T_GREEN      = 16,
    parameter int T_GREEN_PEAK = 8,
    parameter int T_YELLOW     = 5,
    parameter int T_ALLRED     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       run,
    input  logic                       online,
    input  logic                       peak,
    input  logic [N_PHASE-1:0]         req,
    output logic [CNT_W-1:0]           countdown,
    output logic [$clog2(N_PHASE)-1:0] phase_idx,
    output logic [1:0]                 state,
    output logic [N_PHASE-1:0]         lamp_g,
    output logic [N_PHASE-1:0]         lamp_y,
    output logic [N_PHASE-1:0]         lamp_r,
    output logic                       phase_done
);
    localparam int IW = $clog2(N_PHASE);
    localparam int CNT_MAX = (2 ** CNT_W) - 1;
    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN);
    localparam logic [CNT_W-1:0] LD_PEAK   = CNT_W'(T_GREEN_PEAK);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED);
    localparam logic [N_PHASE-1:0] ONE_OH = {{(N_PHASE-1){1'b0}}, 1'b1};

    if (N_PHASE < 2 || N_PHASE > 8 || T_GREEN > CNT_MAX || T_GREEN_PEAK > CNT_MAX ||
        T_YELLOW > CNT_MAX || T_ALLRED > CNT_MAX) begin : g_param_check
        $error("tlc_phase_ctrl: illegal parameter combination");
    end

    tlc_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, green_ld_s;
    logic [IW-1:0]      idx_q, idx_d, pick_idx_s, inc_idx_s;
    logic               pick_found_s;
    logic [N_PHASE-1:0] latch_q, latch_d, cur_oh_s, set_s, clr_s;
    logic [N_PHASE-1:0] lamp_g_q, lamp_g_d, lamp_y_q, lamp_y_d, lamp_r_q, lamp_r_d;
    logic               done_q, done_d;

    tlc_rr_pick #(.N_PHASE(N_PHASE)) u_pick (
        .latch    (latch_q),
        .cur_idx  (idx_q),
        .next_idx (pick_idx_s),
        .found    (pick_found_s)
    );

    // Sequencing, countdown and demand-latch next state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        clr_s      = {N_PHASE{1'b0}};
        green_ld_s = peak ? LD_PEAK : LD_GREEN;
        cur_oh_s   = ONE_OH << idx_q;
        inc_idx_s  = (idx_q == IW'(N_PHASE - 1)) ? {IW{1'b0}} : idx_q + IW'(1);
        if (tick && run) begin
            if (cnt_q != {CNT_W{1'b0}}) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                case (state_q)
                    ST_GREEN: begin
                        if (online || (|(latch_q & ~cur_oh_s))) begin
                            state_d = ST_YELLOW;
                            cnt_d   = LD_YELLOW;
                        end else begin
                            cnt_d   = green_ld_s;
                        end
                    end
                    ST_YELLOW: begin
                        state_d = ST_ALLRED;
                        cnt_d   = LD_ALLRED;
                    end
                    ST_ALLRED: begin
                        done_d  = 1'b1;
                        idx_d   = (online || !pick_found_s) ? inc_idx_s : pick_idx_s;
                        state_d = ST_GREEN;
                        cnt_d   = green_ld_s;
                        clr_s   = ONE_OH << idx_d;
                    end
                    default: begin
                        state_d = ST_ALLRED;
                        cnt_d   = LD_ALLRED;
                    end
                endcase
            end
        end else begin
            cnt_d = cnt_q;
        end
        // The phase currently in green is already served, so its request is not latched.
        set_s   = req & ~((state_q == ST_GREEN) ? cur_oh_s : {N_PHASE{1'b0}});
        latch_d = (latch_q | set_s) & ~clr_s;
    end

    // Lamp drives derived from the next state so they update with it.
    always_comb begin
        lamp_g_d = {N_PHASE{1'b0}};
        lamp_y_d = {N_PHASE{1'b0}};
        lamp_r_d = {N_PHASE{1'b0}};
        for (int k = 0; k < N_PHASE; k++) begin
            {lamp_r_d[k], lamp_y_d[k], lamp_g_d[k]} = lamp_code(state_d, idx_d == IW'(k));
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_GREEN;
            cnt_q    <= LD_GREEN;
            idx_q    <= {IW{1'b0}};
            latch_q  <= {N_PHASE{1'b0}};
            done_q   <= 1'b0;
            lamp_g_q <= ONE_OH;
            lamp_y_q <= {N_PHASE{1'b0}};
            lamp_r_q <= ~ONE_OH;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            latch_q  <= latch_d;
            done_q   <= done_d;
            lamp_g_q <= lamp_g_d;
            lamp_y_q <= lamp_y_d;
            lamp_r_q <= lamp_r_d;
        end
    end

    assign countdown  = cnt_q;
    assign phase_idx  = idx_q;
    assign state      = state_q;
    assign lamp_g     = lamp_g_q;
    assign lamp_y     = lamp_y_q;
    assign lamp_r     = lamp_r_q;
    assign phase_done = done_q;

endmodule

// File: doc/tlc_phase_ctrl.md
Name: tlc_phase_ctrl

Overview:
Parametrised N-phase traffic-light controller, successor to the fixed two-approach controller.
- Sequences GREEN -> YELLOW -> ALL-RED per phase, with per-state countdown and demand-driven phase skipping.
- Sits behind the divide second-strobe generator and drives the lamp and countdown-display outputs.
- Adds an all-red clearance interval, sticky per-phase demand latches, round-robin skip and a peak-hour green time.

Parameters:
N_PHASE, 2, number of signal phases (2..8)
CNT_W, 5, countdown width
T_GREEN, 16, normal green load value
T_GREEN_PEAK, 8, green load value while peak=1
T_YELLOW, 5, yellow load value
T_ALLRED, 2, all-red clearance load value

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-cycle strobe, 1 Hz, from divide
run  in  1  1=count, 0=freeze (state and countdown hold)
online  in  1  1=fixed-time cycling, 0=demand-actuated
peak  in  1  selects T_GREEN_PEAK at green load
req  in  N_PHASE  per-phase demand, level or pulse
countdown  out  CNT_W  remaining ticks in current state
phase_idx  out  $clog2(N_PHASE)  phase currently served
state  out  2  00=GREEN, 01=YELLOW, 10=ALLRED
lamp_g / lamp_y / lamp_r  out  N_PHASE each  one-hot-per-phase lamp drives
phase_done  out  1  one-cycle pulse on ALLRED exit

Behaviour:
Reset:
- rst sampled on clk; it overrides tick and run.
- After reset: state=GREEN, phase_idx=0, countdown=T_GREEN (ignores peak), demand latches=0, phase_done=0.
- Lamps after reset: lamp_g=1<<0, lamp_y=0, lamp_r=all ones except bit 0.
- Mid-operation reset: same values, applied on the next edge.

Timing:
- The counter advances only on cycles with tick=1 and run=1.
- If countdown>0, it decrements by 1.
- If countdown==0, a transition is taken on that same edge. Each state therefore lasts load+1 ticks.

Demand latch:
- Bit k is set when req[k]=1, except when k==phase_idx and state==GREEN (current green already serves it).
- Bit k is cleared on the edge that enters GREEN for phase k.
- A set and a clear of the same bit on the same edge: clear wins.

Transitions at countdown==0:
- GREEN, online=1: go to YELLOW, load T_YELLOW.
- GREEN, online=0, any latch bit set for another phase: go to YELLOW, load T_YELLOW.
- GREEN, online=0, no latch bit set: stay GREEN, reload the green value (extension).
- YELLOW: go to ALLRED, load T_ALLRED.
- ALLRED: pulse phase_done.
  - online=1: phase_idx = (phase_idx+1) mod N_PHASE.
  - online=0: phase_idx = first latched phase scanning upward from phase_idx+1 with wrap. If none is latched, phase_idx+1 with wrap.
  - Then enter GREEN and load the green value.
- Green value is T_GREEN_PEAK if peak=1, else T_GREEN, sampled at load time.

Lamps:
- Registered, updated on the same edge as state.
- Exactly one of g/y/r is set per phase.
- Only phase_idx may be green or yellow. During ALLRED every bit of lamp_r=1.

Freeze:
- run=0 holds state, countdown and phase_idx.
- Demand latching continues while frozen.

Width rule:
- Every T_* must be ≤ 2^CNT_W−1 and N_PHASE must be ≥2. Violations are an elaboration-time error.

Decomposition:
- Shared package tlc_pkg: state encoding constants (ST_GREEN, ST_YELLOW, ST_ALLRED) and a lamp-pattern helper function.
- One sub-module, tlc_rr_pick: combinational round-robin next-phase selector (latch vector plus current index -> next index, found flag).

Test Plan:
- Reset, online=1, N_PHASE=2, run=1, tick every 4 clk -> GREEN p0 for 17 ticks, YELLOW 6, ALLRED 3, then GREEN p1; phase_done pulses once.
- online=0, no req for 40 ticks -> p0 stays GREEN, countdown reloads 16 after every 0, never goes YELLOW.
- N_PHASE=4, online=0, req pulse on phase 2 only during p0 green -> p0 YELLOW/ALLRED then GREEN p2 (phase 1 skipped); latch[2] clears on green entry.
- peak=1 asserted before the ALLRED->GREEN edge -> countdown loads 8; peak dropped mid-green -> current green is not reloaded.
- run=0 held for 10 ticks during YELLOW at countdown=3 -> countdown stays 3; req during freeze is still latched.
- rst asserted at YELLOW countdown=2 on a tick cycle -> next edge gives GREEN p0, countdown=16, latches cleared.
